data_memory: RTL
================

Name: data_memory

Overview:
- Data-memory responder for the MIPS core: services the load/store requests the execute stage issues (store address, store data, memory write enable).
- Word-organised on-chip RAM with byte/half/word lanes, load sign/zero extension and a programmable wait-state count, behind a valid/ready request and a single-cycle response pulse.
- Sits between the execute stage and write-back; one outstanding request at a time.

Parameters:
- WORD_SIZE, 32, data and address width.
- DEPTH, 256, number of WORD_SIZE words stored.
- DEPTH_BITS, $clog2(DEPTH), word-index width.
- WAIT_STATES, 1, extra cycles between acceptance and access (0 allowed).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- signal_we_memory  input  1  1 = store, 0 = load.
- addres_memory  input  WORD_SIZE  byte address.
- data_write_memory  input  WORD_SIZE  store data; lanes taken from LSBs.
- access_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- load_unsigned  input  1  1 = zero-extend loads (LBU/LHU), 0 = sign-extend.
- rsp_valid  output  1  one-cycle completion pulse.
- data_read_memory  output  WORD_SIZE  load result, valid with rsp_valid.
- fault_misaligned  output  1  request faulted, valid with rsp_valid.

Behaviour:
- Reset:
  - Asynchronous on rst_n low: FSM goes to IDLE.
  - req_ready=1, rsp_valid=0, data_read_memory=0, fault_misaligned=0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE: req_ready=1. On req_valid, latch address, data, size, unsigned flag and we. Go to WAIT if WAIT_STATES>0, else ACCESS. Wait counter loads WAIT_STATES-1.
  - WAIT: req_ready=0. Counter decrements each cycle; go to ACCESS when it reaches 0.
  - ACCESS: req_ready=0. Perform the access on the latched request, drive the response registers, return to IDLE.
- Response timing:
  - rsp_valid is registered and pulses for exactly the cycle after ACCESS.
  - Acceptance at edge N gives rsp_valid high in the cycle after edge N+WAIT_STATES+1.
  - req_ready returns high in that same cycle, so back-to-back requests are allowed with no dead cycle.
  - Inputs are ignored while req_ready=0.
- Addressing:
  - Word index = addr[DEPTH_BITS+1:2]; upper bits are ignored (wrap modulo DEPTH).
  - Byte order is little-endian: byte lane k = bits 8k+7:8k, selected by addr[1:0].
- Alignment:
  - Half requires addr[0]=0; word requires addr[1:0]=00.
  - access_size=11 is treated as misaligned.
  - On a fault: no RAM write, data_read_memory=0, fault_misaligned=1 with the rsp_valid pulse.
- Stores:
  - Byte writes only lane addr[1:0], using data bits 7:0.
  - Half writes lanes {addr[1],0} and {addr[1],1}, using data bits 15:0.
  - Word writes all lanes.
  - Unwritten lanes are preserved.
  - A store response drives data_read_memory=0.
  - The RAM write occurs only at the ACCESS edge.
- Loads:
  - The selected lane(s) are right-justified.
  - load_unsigned=1 zero-extends; 0 sign-extends from bit 7 (byte) or bit 15 (half).
  - Word loads return the word unchanged; load_unsigned is ignored.
- Reset mid-operation: the pending request is dropped. A store in WAIT never reaches the RAM, no response is produced, and the block is back in IDLE with req_ready=1.
- Read after write: a load accepted after a store's response observes the stored value.

Test Plan:
- Word store then load: SW 0xDEADBEEF to addr 0x10, then LW 0x10 -> rsp_valid 2 cycles after each acceptance (WAIT_STATES=1), read 0xDEADBEEF, fault_misaligned=0.
- Byte lanes and sign extension: after the above, SB 0x80 to 0x11, then:
  - LW 0x10 -> 0xDEAD80EF.
  - LB 0x11 -> 0xFFFFFF80.
  - LBU 0x11 -> 0x00000080.
  - LH 0x12 -> 0xFFFFDEAD.
  - LHU 0x12 -> 0x0000DEAD.
- Misalignment: SW to 0x22 and LH from 0x13 -> fault_misaligned=1 with data 0; a subsequent LW 0x20 shows the word unchanged from its prior value.
- Wrap and back-to-back timing:
  - SW 0x11223344 to 0x400 (DEPTH=256), then LW 0x000 -> 0x11223344.
  - With req_valid held high and WAIT_STATES=0, accepts occur every 2 cycles and rsp_valid pulses every 2 cycles.
- Reset in WAIT: WAIT_STATES=3, SW 0xCAFEF00D to 0x40, rst_n low for 1 cycle during WAIT -> no rsp_valid, req_ready=1 after reset, LW 0x40 returns the pre-store value.
- Ready gating: a request presented while req_ready=0 with different address/data -> ignored; the in-flight response matches the originally accepted request.

Source files
------------

// File: rtl/data_memory.sv
// rtl/data_memory.sv - Load/store data memory with byte lanes, load extension and wait states
module data_memory #(
  parameter int WORD_SIZE   = 32,
  parameter int DEPTH       = 256,
  parameter int DEPTH_BITS  = $clog2(DEPTH),
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 signal_we_memory,
  input  logic [WORD_SIZE-1:0] addres_memory,
  input  logic [WORD_SIZE-1:0] data_write_memory,
  input  logic [1:0]           access_size,
  input  logic                 load_unsigned,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] data_read_memory,
  output logic                 fault_misaligned
);

  localparam int CNT_W     = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam int WAIT_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam int ABITS     = DEPTH_BITS + 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 accept;
  logic                 do_access;
  logic                 cnt_zero;
  logic [CNT_W-1:0]     wait_cnt;

  logic                 we_q;
  logic                 uns_q;
  logic [1:0]           size_q;
  logic [ABITS-1:0]     addr_q;
  logic [WORD_SIZE-1:0] wdata_q;

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [DEPTH_BITS-1:0] word_idx;
  logic [1:0]           lane;
  logic                 misaligned;
  logic [WORD_SIZE-1:0] rd_word;
  logic [WORD_SIZE-1:0] wr_word;
  logic [WORD_SIZE-1:0] ld_val;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;

  // Address bits above the word index wrap the RAM and are deliberately dropped.
  logic                 unused_addr_hi;
  assign unused_addr_hi = ^addres_memory[WORD_SIZE-1:ABITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt_zero) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    accept    = req_ready && req_valid;
    do_access = (state == S_ACCESS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= CNT_W'(WAIT_LOAD);
    end else if (state == S_WAIT && !cnt_zero) begin
      wait_cnt <= wait_cnt - CNT_W'(1);
    end
  end

  assign cnt_zero = (wait_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= signal_we_memory;
      uns_q   <= load_unsigned;
      size_q  <= access_size;
      addr_q  <= addres_memory[ABITS-1:0];
      wdata_q <= data_write_memory;
    end
  end

  assign word_idx = addr_q[ABITS-1:2];
  assign lane     = addr_q[1:0];
  assign rd_word  = mem[word_idx];
  assign ld_byte  = rd_word[{lane, 3'b000} +: 8];
  assign ld_half  = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lane[0];
      SZ_WORD: misaligned = (lane != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Read-modify-write merge so lanes outside the store keep their contents.
  always_comb begin
    wr_word = rd_word;
    case (size_q)
      SZ_BYTE: wr_word[{lane, 3'b000} +: 8]     = wdata_q[7:0];
      SZ_HALF: wr_word[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: wr_word = wdata_q;
    endcase
  end

  always_comb begin
    case (size_q)
      SZ_BYTE: ld_val = {{(WORD_SIZE-8){~uns_q & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_val = {{(WORD_SIZE-16){~uns_q & ld_half[15]}}, ld_half};
      default: ld_val = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_access && we_q && !misaligned) begin
      mem[word_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid        <= 1'b0;
      data_read_memory <= '0;
      fault_misaligned <= 1'b0;
    end else begin
      rsp_valid <= do_access;
      if (do_access) begin
        fault_misaligned <= misaligned;
        data_read_memory <= (we_q || misaligned) ? '0 : ld_val;
      end
    end
  end

endmodule
